// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters.
// A grant is held from issue until the matching response returns. The
// response is steered back to the granted requester only.
module mem_port_arbiter #(
  parameter  int NR_REQ  = 2,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int GRANT_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
  localparam int MASK_W  = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NR_REQ-1:0]          req_valid,
  output logic [NR_REQ-1:0]          req_ready,
  input  logic [NR_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NR_REQ-1:0]          req_wen,
  input  logic [NR_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NR_REQ*MASK_W-1:0]   req_wmask,
  output logic [NR_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_wen,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [MASK_W-1:0]          mem_wmask,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_rdata,
  output logic [GRANT_W-1:0]         grant_idx,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [GRANT_W-1:0] last_grant;
  logic [GRANT_W-1:0] pick;
  int                 pick_dist;
  int                 best_dist;

  // Round-robin pick: the valid requester closest after last_grant (mod NR_REQ) wins.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick      = '0;
    pick_dist = 0;
    best_dist = NR_REQ;
    for (int n = 0; n < NR_REQ; n++) begin
      if (req_valid[n]) begin
        pick_dist = n - int'(last_grant) - 1;
        if (pick_dist < 0) pick_dist = pick_dist + NR_REQ;
        if (pick_dist < best_dist) begin
          best_dist = pick_dist;
          pick      = GRANT_W'(n);
        end
      end
    end
  end

  // Request fields of the granted requester steered to the shared port.
  always_comb begin
    mem_addr  = req_addr[ADDR_W-1:0];
    mem_wen   = req_wen[0];
    mem_wdata = req_wdata[DATA_W-1:0];
    mem_wmask = req_wmask[MASK_W-1:0];
    for (int n = 1; n < NR_REQ; n++) begin
      if (grant_idx == GRANT_W'(n)) begin
        mem_addr  = req_addr[n*ADDR_W +: ADDR_W];
        mem_wen   = req_wen[n];
        mem_wdata = req_wdata[n*DATA_W +: DATA_W];
        mem_wmask = req_wmask[n*MASK_W +: MASK_W];
      end
    end
  end

  // Next-state and handshake outputs of the IDLE -> ISSUE -> WAIT transaction cycle.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    req_ready     = '0;
    rsp_valid     = '0;
    case (state)
      IDLE: begin
        if (|req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        for (int n = 0; n < NR_REQ; n++) begin
          if (grant_idx == GRANT_W'(n)) req_ready[n] = mem_req_ready;
        end
        if (mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        for (int n = 0; n < NR_REQ; n++) begin
          if (grant_idx == GRANT_W'(n)) rsp_valid[n] = mem_rsp_valid;
        end
        if (mem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_rdata = mem_rsp_rdata;
  assign busy      = (state != IDLE);

  // State, grant and round-robin pointer registers; reset drops any outstanding transaction.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, matching flop behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= GRANT_W'(NR_REQ - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && |req_valid) grant_idx <= pick;
      if (state == ISSUE && mem_req_ready) last_grant <= grant_idx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NR = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*32-1:0]  req_addr;
  logic [NR-1:0]     req_wen;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*4-1:0]   req_wmask;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;
  logic [0:0]        grant_idx;
  logic              busy;

  logic [31:0] r_addr  [NR];
  logic [31:0] r_wdata [NR];
  logic [3:0]  r_wmask [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_addr[g*32 +: 32] = r_addr[g];
    assign req_wdata[g*32 +: 32] = r_wdata[g];
    assign req_wmask[g*4 +: 4]  = r_wmask[g];
  end

  mem_port_arbiter #(.NR_REQ(NR), .ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .grant_idx     (grant_idx),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the port, whether its request was
  // accepted, the last registered pick, and the round-robin pointer.
  int m_owner;
  bit m_issued;
  int m_g;
  int m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    r_addr[n]  = addr;
    req_wen[n] = wen;
    r_wdata[n] = wdata;
    r_wmask[n] = wmask;
  endtask

  // Compare every DUT output against the model, shortly after inputs settle.
  task automatic compare();
    logic [NR-1:0] e_rr;
    logic [NR-1:0] e_rv;
    logic [31:0]   e_addr;
    logic [31:0]   e_wdata;
    logic [3:0]    e_wmask;
    logic          e_wen;
    #1;
    e_rr = '0; e_rv = '0; e_addr = '0; e_wdata = '0; e_wmask = '0; e_wen = 1'b0;
    for (int n = 0; n < NR; n++) begin
      if (n == m_owner && !m_issued) e_rr[n] = mem_req_ready;
      if (n == m_owner && m_issued)  e_rv[n] = mem_rsp_valid;
      if (n == m_g) begin
        e_addr = r_addr[n]; e_wen = req_wen[n]; e_wdata = r_wdata[n]; e_wmask = r_wmask[n];
      end
    end
    check("busy", busy, m_owner >= 0);
    check("mem_req_valid", mem_req_valid, m_owner >= 0 && !m_issued);
    check("req_ready", req_ready, e_rr);
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_onehot", $countones(rsp_valid) <= 1, 1);
    check("rsp_rdata", rsp_rdata, mem_rsp_rdata);
    check("grant_idx", grant_idx, m_g);
    if (m_owner >= 0 && !m_issued) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_wen", mem_wen, e_wen);
      check("mem_wdata", mem_wdata, e_wdata);
      check("mem_wmask", mem_wmask, e_wmask);
    end
  endtask

  // Apply the rules for the coming clock edge to the model, then move to the next low phase.
  task automatic advance();
    if (rst) begin
      m_owner = -1; m_issued = 0; m_g = 0; m_last = NR - 1;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= NR; i++) begin
        int c;
        c = (m_last + i) % NR;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c;
          m_g     = c;
        end
      end
    end else if (!m_issued) begin
      if (mem_req_ready) begin
        m_issued = 1;
        m_last   = m_owner;
      end
    end else if (mem_rsp_valid) begin
      m_owner  = -1;
      m_issued = 0;
    end
    @(negedge clk);
  endtask

  int order [4];
  int k;
  int rsp_wait;
  bit accept;

  initial begin
    rst = 1'b1; req_valid = '0; req_wen = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    for (int n = 0; n < NR; n++) set_req(n, 32'h0, 1'b0, 32'h0, 4'h0);
    m_owner = -1; m_issued = 0; m_g = 0; m_last = NR - 1;
    @(negedge clk);
    advance();

    // Reset state
    rst = 1'b0;
    compare();
    check("rst_busy", busy, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_idx", grant_idx, 0);

    // Single read from requester 0
    req_valid = 2'b01; set_req(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0); mem_req_ready = 1'b1;
    compare(); check("t1_idle_mrv", mem_req_valid, 0); advance();
    compare();
    check("t1_mrv", mem_req_valid, 1);
    check("t1_addr", mem_addr, 32'h8000_0000);
    check("t1_ready", req_ready, 2'b01);
    advance();
    req_valid = 2'b00; mem_req_ready = 1'b0;
    compare(); advance();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
    compare();
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    advance();
    mem_rsp_valid = 1'b0;
    compare(); check("t1_idle_after", busy, 0); advance();

    // Stray response while idle
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0BAD_0BAD;
    compare(); check("t6_rsp_valid", rsp_valid, 2'b00); advance();
    mem_rsp_valid = 1'b0;
    compare(); check("t6_busy", busy, 0); advance();

    // Both requesters valid continuously: alternating grants from a fresh reset
    rst = 1'b1; compare(); advance(); rst = 1'b0;
    req_valid = 2'b11; mem_req_ready = 1'b1; k = 0;
    for (int cyc = 0; cyc < 80 && !(k == 4 && m_owner < 0); cyc++) begin
      mem_rsp_valid = (m_owner >= 0 && m_issued);
      compare();
      if (mem_req_valid && |req_ready && k < 4) begin
        order[k] = int'(grant_idx);
        k++;
      end
      advance();
      if (k == 4) req_valid = 2'b00;
    end
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    check("t2_count", k, 4);
    check("t2_order0", order[0], 0);
    check("t2_order1", order[1], 1);
    check("t2_order2", order[2], 0);
    check("t2_order3", order[3], 1);

    // LSU write stalled by the port for three cycles
    req_valid = 2'b10; set_req(1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b0011);
    compare(); advance();
    for (int i = 0; i < 3; i++) begin
      compare();
      check("t3_addr", mem_addr, 32'h8000_0010);
      check("t3_wdata", mem_wdata, 32'h1234_5678);
      check("t3_wmask", mem_wmask, 4'b0011);
      check("t3_wen", mem_wen, 1);
      check("t3_ready_low", req_ready, 2'b00);
      advance();
    end
    mem_req_ready = 1'b1;
    compare(); check("t3_ready_hi", req_ready, 2'b10); advance();
    req_valid = 2'b00;
    compare(); check("t3_ready_after", req_ready, 2'b00); advance();
    mem_rsp_valid = 1'b1;
    compare(); check("t3_rsp_valid", rsp_valid, 2'b10); advance();
    mem_rsp_valid = 1'b0;
    compare(); advance();

    // No preemption: requester 1 arrives while requester 0 waits
    req_valid = 2'b01; set_req(0, 32'h8000_0100, 1'b0, 32'h0, 4'h0);
    compare(); advance();
    compare(); advance();
    req_valid = 2'b10;
    compare(); check("t4_hold_grant", grant_idx, 0); check("t4_no_issue", mem_req_valid, 0); advance();
    compare(); advance();
    mem_rsp_valid = 1'b1;
    compare(); check("t4_rsp0", rsp_valid, 2'b01); advance();
    mem_rsp_valid = 1'b0;
    compare(); check("t4_bubble", mem_req_valid, 0); advance();
    compare(); check("t4_issue1", mem_req_valid, 1); check("t4_grant1", grant_idx, 1); advance();
    req_valid = 2'b00; mem_rsp_valid = 1'b1;
    compare(); advance();
    mem_rsp_valid = 1'b0;

    // Reset in WAIT drops the transaction
    req_valid = 2'b01;
    compare(); advance();
    compare(); advance();
    req_valid = 2'b00; rst = 1'b1;
    compare(); advance();
    rst = 1'b0;
    compare(); check("t5_busy", busy, 0); check("t5_mrv", mem_req_valid, 0); advance();
    mem_rsp_valid = 1'b1;
    compare(); check("t5_late_rsp", rsp_valid, 2'b00); advance();
    mem_rsp_valid = 1'b0;

    // Randomized traffic against the model
    rsp_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < NR; n++) begin
        if (!(m_owner == n && !m_issued)) begin
          req_valid[n] = ($urandom_range(0, 2) != 0);
          set_req(n, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
      end
      mem_req_ready = 1'($urandom_range(0, 1));
      if (m_owner >= 0 && m_issued) begin
        if (rsp_wait == 0) mem_rsp_valid = 1'b1;
        else begin
          mem_rsp_valid = 1'b0;
          rsp_wait--;
        end
      end else begin
        mem_rsp_valid = ($urandom_range(0, 15) == 0);
      end
      mem_rsp_rdata = $urandom;
      accept = !rst && m_owner >= 0 && !m_issued && mem_req_ready;
      compare();
      advance();
      if (accept) rsp_wait = $urandom_range(0, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
